// File: rtl/issue_scoreboard_if.sv
// -----------------------------------------------------------------------------
// issue_scoreboard_if
//   Groups the decode-side issue handshake, the writeback port and the flush
//   request that the issue scoreboard consumes.
//
//   master : the decode/writeback side. It drives the operation, the writeback
//            and the flush, and receives iss_ok.
//   slave  : the scoreboard. It receives the operation, the writeback and the
//            flush, and drives iss_ok.
//
//   Signals:
//     iss_v              decode presents a valid operation
//     rs1_ad / rs1_used  first source register and its read enable
//     rs2_ad / rs2_used  second source register and its read enable
//     rd_ad  / rd_used   destination register and its write enable
//     iss_ok             issue granted this cycle (combinational)
//     res_v  / res_adr   writeback valid and its destination register
//     flush              discard all in-flight tracking
// -----------------------------------------------------------------------------
interface issue_scoreboard_if;
    logic       iss_v;
    logic [4:0] rs1_ad;
    logic       rs1_used;
    logic [4:0] rs2_ad;
    logic       rs2_used;
    logic [4:0] rd_ad;
    logic       rd_used;
    logic       iss_ok;
    logic       res_v;
    logic [4:0] res_adr;
    logic       flush;

    modport master (
        output iss_v, rs1_ad, rs1_used, rs2_ad, rs2_used, rd_ad, rd_used,
        output res_v, res_adr, flush,
        input  iss_ok
    );

    modport slave (
        input  iss_v, rs1_ad, rs1_used, rs2_ad, rs2_used, rd_ad, rd_used,
        input  res_v, res_adr, flush,
        output iss_ok
    );
endinterface

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//   Issue-side hazard controller. Each architectural register has a small
//   pending-write counter. Issue is held on read-after-write hazards and when
//   the destination counter is saturated. Results returning on the writeback
//   port retire pending writes. Register 0 is hard-wired zero and is never busy.
//
//   Parameters:
//     NREG   number of architectural registers (default 32)
//     CNT_W  pending-counter width; up to 2^CNT_W-1 writes in flight per reg
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     sb           issue/writeback/flush interface (slave side)
//     busy_o       bit i set when register i has a pending write (registered)
//     stall_o      an operation is presented but not granted
//     err_o        sticky; a writeback arrived for a register with no pending write
//     stall_cnt_o  stall-cycle counter, present only when SCOREBOARD_PERF_EN
//                  is defined
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    issue_scoreboard_if.slave   sb,
    output logic [NREG-1:0]     busy_o,
    output logic                stall_o,
    output logic                err_o
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic             err_q;

    logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, res_cnt;
    logic             raw1, raw2, ovf;
    logic             iss_ok;
    logic             inc, wb, same_reg, err_set;

    // Counter lookups. Addresses at or beyond NREG (and register 0) read as 0.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        res_cnt = '0;
        for (int i = 1; i < NREG; i++) begin
            if (int'(sb.rs1_ad)  == i) rs1_cnt = cnt_q[i];
            if (int'(sb.rs2_ad)  == i) rs2_cnt = cnt_q[i];
            if (int'(sb.rd_ad)   == i) rd_cnt  = cnt_q[i];
            if (int'(sb.res_adr) == i) res_cnt = cnt_q[i];
        end
    end

    // Hazards look only at current state: a writeback this cycle does not
    // release a dependent issue until the next cycle.
    assign raw1   = sb.rs1_used && (rs1_cnt != '0);
    assign raw2   = sb.rs2_used && (rs2_cnt != '0);
    assign ovf    = sb.rd_used && (sb.rd_ad != '0) && (rd_cnt == CNT_MAX);
    assign iss_ok = rst_n && sb.iss_v && !sb.flush && !raw1 && !raw2 && !ovf;

    assign sb.iss_ok = iss_ok;
    assign stall_o   = rst_n && sb.iss_v && !iss_ok;

    // A flush discards this cycle's issue and writeback, including their
    // effect on the error flag.
    assign inc      = iss_ok && sb.rd_used && (sb.rd_ad != '0);
    assign wb       = sb.res_v && (sb.res_adr != '0) && !sb.flush;
    // Issue and retire on the same register cancel; that is not an error
    // even when the counter was 0.
    assign same_reg = inc && wb && (sb.rd_ad == sb.res_adr);
    assign err_set  = wb && !same_reg && (res_cnt == '0);

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 1; i < NREG; i++) begin
            if (sb.flush) begin
                cnt_d[i] = '0;
            end else if (!same_reg) begin
                if (inc && int'(sb.rd_ad) == i)
                    cnt_d[i] = cnt_q[i] + 1'b1;
                if (wb && int'(sb.res_adr) == i && cnt_q[i] != '0)
                    cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        cnt_d[0] = '0;
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so it is
    // cleared by reset like any other state; a flush alone would leave
    // post-reset contents undefined.
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i]  <= cnt_d[i];
                busy_q[i] <= (cnt_d[i] != '0);
            end
            err_q <= err_q || err_set;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q;

    // Counts every edge with stall_o high; wraps naturally and ignores flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall_o)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//   Self-checking bench for issue_scoreboard: a directed vector table, a
//   hand-written saturation / asynchronous-reset sequence, then randomized
//   traffic compared against a per-register pending-count model.
//   Define SCOREBOARD_PERF_EN to also check stall_cnt_o.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

    localparam int NREG  = 32;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic            clk;
    logic            rst_n;
    logic [NREG-1:0] busy_o;
    logic            stall_o;
    logic            err_o;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0]     stall_cnt_o;
`endif

    issue_scoreboard_if sb_if ();

    issue_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sb          (sb_if),
        .busy_o      (busy_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
`ifdef SCOREBOARD_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            iss_v;
        bit [4:0]      rs1;
        bit            rs1u;
        bit [4:0]      rs2;
        bit            rs2u;
        bit [4:0]      rd;
        bit            rdu;
        bit            res_v;
        bit [4:0]      res;
        bit            flush;
        bit            ok;     // expected iss_ok this cycle
        bit [NREG-1:0] busy;   // expected busy_o after the edge
        bit            err;    // expected err_o after the edge
    } vec_t;

    vec_t tbl [19];
    vec_t ovf_seq [10];

    int checks     = 0;
    int errors     = 0;
    int exp_stalls = 0;

    // Reference model state for the random phase.
    int m_cnt [NREG];
    bit m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        sb_if.iss_v    = v.iss_v;
        sb_if.rs1_ad   = v.rs1;
        sb_if.rs1_used = v.rs1u;
        sb_if.rs2_ad   = v.rs2;
        sb_if.rs2_used = v.rs2u;
        sb_if.rd_ad    = v.rd;
        sb_if.rd_used  = v.rdu;
        sb_if.res_v    = v.res_v;
        sb_if.res_adr  = v.res;
        sb_if.flush    = v.flush;
    endtask

    task automatic idle();
        vec_t z;
        z = '{default: 0};
        drive(z);
    endtask

    // One cycle: drive on the falling edge, check the combinational grant,
    // then check registered state just after the rising edge.
    task automatic run(input string name, input vec_t v);
        bit exp_stall;
        @(negedge clk);
        drive(v);
        #1;
        exp_stall = v.iss_v && !v.ok;
        check({name, ".iss_ok"}, 64'(sb_if.iss_ok), 64'(v.ok));
        check({name, ".stall"},  64'(stall_o),      64'(exp_stall));
        if (exp_stall) exp_stalls++;
        @(posedge clk);
        #1;
        check({name, ".busy"}, 64'(busy_o), 64'(v.busy));
        check({name, ".err"},  64'(err_o),  64'(v.err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_stalls = 0;
    endtask

    task automatic check_perf(input string name);
`ifdef SCOREBOARD_PERF_EN
        check(name, 64'(stall_cnt_o), 64'(exp_stalls));
`else
        if (name.len() == 0) $display("empty perf check name");
`endif
    endtask

    initial begin
        vec_t v;
        //           iss rs1 u  rs2 u  rd u  rv res fl  ok busy        err
        tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 32'h0000_0020, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 32'h0000_0000, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 32'h0000_0008, 0};
        tbl[3]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0008, 0};
        tbl[4]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0008, 0};
        tbl[5]  = '{1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0000_0000, 0};
        tbl[6]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 32'h0000_0200, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 1, 32'h0000_0200, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0000_0000, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0000_0000, 1};
        tbl[11] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 1};
        tbl[12] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 1};
        tbl[13] = '{1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 32'h0000_0010, 1};
        tbl[14] = '{1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1, 32'h0000_0050, 1};
        tbl[15] = '{1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 32'h0000_0050, 1};
        tbl[16] = '{1, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0, 32'h0000_0000, 1};
        tbl[17] = '{1, 4, 1, 6, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 32'h0000_0000, 1};

        ovf_seq[0] = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 32'h0000_0080, 0};
        ovf_seq[1] = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 32'h0000_0080, 0};
        ovf_seq[2] = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 32'h0000_0080, 0};
        ovf_seq[3] = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0000_0080, 0};
        ovf_seq[4] = '{1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0, 32'h0000_0080, 0};
        ovf_seq[5] = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 32'h0000_0080, 0};
        ovf_seq[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0000_0080, 0};
        ovf_seq[7] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0000_0080, 0};
        ovf_seq[8] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0000_0000, 0};
        ovf_seq[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0000_0000, 1};

        // Reset state, with an operation presented during reset.
        idle();
        rst_n = 1'b0;
        sb_if.iss_v = 1'b1;
        #12;
        check("rst.iss_ok", 64'(sb_if.iss_ok), 64'd0);
        check("rst.stall",  64'(stall_o),      64'd0);
        check("rst.busy",   64'(busy_o),       64'd0);
        check("rst.err",    64'(err_o),        64'd0);
        check_perf("rst.stall_cnt");
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i]);
        check_perf("tbl.stall_cnt");

        // Saturation: three writes to r7 in flight, the fourth waits for a
        // retire; the remaining count is proven by retiring exactly three.
        do_reset();
        foreach (ovf_seq[i]) run($sformatf("ovf%0d", i), ovf_seq[i]);
        check_perf("ovf.stall_cnt");

        // Asynchronous reset in the middle of a cycle with state present.
        v = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 32'h0000_0080, 1};
        run("pre_arst", v);
        @(negedge clk);
        v = '{1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0};
        drive(v);
        #2;
        rst_n = 1'b0;
        #1;
        exp_stalls = 0;
        check("arst.busy",   64'(busy_o),       64'd0);
        check("arst.err",    64'(err_o),        64'd0);
        check("arst.iss_ok", 64'(sb_if.iss_ok), 64'd0);
        check("arst.stall",  64'(stall_o),      64'd0);
        check_perf("arst.stall_cnt");
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Randomized traffic against a pending-count model. Addresses are
        // drawn from a small range so hazards and saturation occur often.
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit exp_ok, exp_stall;
            logic [NREG-1:0] exp_busy;
            int rs1, rs2, rd, res;
            @(negedge clk);
            v = '{default: 0};
            v.iss_v = ($urandom_range(0, 3) != 0);
            v.rs1   = 5'($urandom_range(0, 7));
            v.rs1u  = 1'($urandom_range(0, 1));
            v.rs2   = 5'($urandom_range(0, 7));
            v.rs2u  = 1'($urandom_range(0, 1));
            v.rd    = 5'($urandom_range(0, 7));
            v.rdu   = ($urandom_range(0, 3) != 0);
            v.res   = 5'($urandom_range(0, 7));
            v.res_v = (m_cnt[v.res] > 0) ? 1'($urandom_range(0, 1))
                                         : ($urandom_range(0, 29) == 0);
            v.flush = ($urandom_range(0, 39) == 0);
            drive(v);
            rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; res = v.res;

            exp_ok = v.iss_v && !v.flush
                  && !(v.rs1u && m_cnt[rs1] > 0)
                  && !(v.rs2u && m_cnt[rs2] > 0)
                  && !(v.rdu && rd != 0 && m_cnt[rd] == MAXC);
            exp_stall = v.iss_v && !exp_ok;
            #1;
            check("rnd.iss_ok", 64'(sb_if.iss_ok), 64'(exp_ok));
            check("rnd.stall",  64'(stall_o),      64'(exp_stall));
            if (exp_stall) exp_stalls++;

            if (v.flush) begin
                for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
            end else begin
                bit does_inc, does_wb;
                does_inc = exp_ok && v.rdu && rd != 0;
                does_wb  = v.res_v && res != 0;
                if (!(does_inc && does_wb && rd == res)) begin
                    if (does_inc) m_cnt[rd] = m_cnt[rd] + 1;
                    if (does_wb) begin
                        if (m_cnt[res] > 0) m_cnt[res] = m_cnt[res] - 1;
                        else                m_err = 1'b1;
                    end
                end
            end
            exp_busy = '0;
            for (int r = 0; r < NREG; r++) exp_busy[r] = (m_cnt[r] != 0);

            @(posedge clk);
            #1;
            check("rnd.busy", 64'(busy_o), 64'(exp_busy));
            check("rnd.err",  64'(err_o),  64'(m_err));
        end
        check_perf("rnd.stall_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue-side hazard controller between the decode stage and the register manager. It tracks in-flight writes to each architectural register with a small per-register pending counter and holds issue on read-after-write and counter-overflow hazards. It retires pending writes as results come back on the calculation units' writeback port. It sequences when decoded operations may read the register file and enter the register-to-calculation pipeline.

## Interface
Parameters:
- `NREG`, default 32: number of architectural registers; register 0 is hard-wired zero.
- `CNT_W`, default 2: width of each pending-write counter; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `iss_v` input 1: decode presents a valid operation.
- `rs1_ad` input 5: first source register address.
- `rs1_used` input 1: the operation reads `rs1_ad`.
- `rs2_ad` input 5: second source register address.
- `rs2_used` input 1: the operation reads `rs2_ad`.
- `rd_ad` input 5: destination register address.
- `rd_used` input 1: the operation writes `rd_ad`.
- `iss_ok` output 1: issue granted this cycle; the operation is consumed.
- `res_v` input 1: writeback valid from the calculation units.
- `res_adr` input 5: writeback destination register.
- `flush` input 1: discard all in-flight tracking (pipeline flush).
- `busy_o` output NREG: bit i set when the counter of register i is non-zero.
- `stall_o` output 1: `iss_v` is high and `iss_ok` is low.
- `err_o` output 1: sticky error; set by a writeback to a register with no pending write.
- `stall_cnt_o` output 32: stall-cycle counter (only when `SCOREBOARD_PERF_EN` is defined).

## Operation
- State:
  - `cnt[i]`, `CNT_W` bits, for i = 1..NREG-1.
  - `cnt[0]` is constant 0, so register 0 is never busy.
- Hazards, evaluated combinationally on current state:
  - RAW1: `rs1_used` and `cnt[rs1_ad]` != 0.
  - RAW2: `rs2_used` and `cnt[rs2_ad]` != 0.
  - OVF: `rd_used`, `rd_ad` != 0, and `cnt[rd_ad]` at maximum.
- `iss_ok` = `iss_v` & !`flush` & !RAW1 & !RAW2 & !OVF.
- There is no same-cycle bypass: a writeback in the current cycle does not clear a hazard seen this cycle.
- Issue effect: when `iss_ok`, `rd_used`, and `rd_ad` != 0, `cnt[rd_ad]` increments.
- Writeback effect: when `res_v` and `res_adr` != 0:
  - if `cnt[res_adr]` != 0, it decrements;
  - otherwise the counter stays at 0 and `err_o` is set.
- Issue and writeback in the same cycle on the same register: the counter is unchanged, and `err_o` is not set even if the counter was 0.
- Writeback to register 0 is ignored and never raises `err_o`.
- Flush: every counter is cleared at the next edge, and any issue or writeback in that cycle is discarded. `err_o` is unaffected by flush.
- `err_o` clears only on reset.

## Timing
- Reset values: all counters 0; `busy_o` = 0; `err_o` = 0; `stall_cnt_o` = 0.
- While reset is asserted, `iss_ok` = 0 and `stall_o` = 0.
- Reset asserted mid-operation clears all state immediately (asynchronous).
- `iss_ok` and `stall_o` are combinational from inputs and current state; no registered handshake delay.
- Counter update latency is 1 cycle:
  - An operation issued at edge N makes `busy_o[rd]` high from cycle N+1.
  - A dependent read is stalled from cycle N+1 onward.
- A writeback sampled at edge N that brings a counter to 0 allows the dependent issue in cycle N+1 (minimum 1 stall cycle after the result).
- OVF boundary: with `CNT_W`=2, a 4th in-flight write to the same rd stalls until one retires.
- `busy_o` is registered state (decode of the counters), glitch-free.

## Configuration
- `SCOREBOARD_PERF_EN` defined:
  - `stall_cnt_o` increments by 1 on every edge where `stall_o` is high.
  - It wraps modulo 2^32, is cleared only by reset, and is unaffected by flush.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then issue `rd`=5 with `iss_v`=1 → `iss_ok`=1; next cycle `busy_o`=0x0000_0020. Then writeback `res_adr`=5 → `busy_o`=0 the following cycle.
- Issue `rd`=3, then immediately issue `rs1`=3 `rs1_used`=1 → `stall_o`=1 and `iss_ok`=0 until the cycle after `res_v` with `res_adr`=3; then `iss_ok`=1 (`stall_cnt_o`=number of stalled cycles when `SCOREBOARD_PERF_EN` is defined).
- Three issues to `rd`=7 with no writeback, then a fourth → the fourth stalls (OVF). One writeback to 7 → the fourth issues on the next cycle; the counter reads 3 afterwards.
- Same-cycle issue `rd`=9 and writeback `res_adr`=9 with counter at 1 → counter stays 1, `busy_o[9]`=1, `err_o`=0. Writeback to 9 with counter 0 and no issue → `err_o`=1 and stays set.
- Issue to `rd`=0 and `rs1_ad`=0 `rs1_used`=1 repeatedly → `iss_ok`=1 every cycle, `busy_o[0]`=0 always.
- Two pending registers (4, 6), assert `flush` with `iss_v`=1 → `iss_ok`=0 that cycle, `busy_o`=0 next cycle. Reset asserted asynchronously mid-cycle → all outputs 0 immediately.
